// File: rtl/mul_arbiter.sv
// Round-robin front end that shares one start/done multiplier among NREQ
// requesters, with a watchdog that completes a hung operation with error.
module mul_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_multiplier,
  input  logic [NREQ*WIDTH-1:0]   req_multiplicand,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_data,
  output logic                    busy,
  output logic                    error,
  output logic                    mul_start,
  output logic [WIDTH-1:0]        mul_multiplier,
  output logic [WIDTH-1:0]        mul_multiplicand,
  input  logic [2*WIDTH-1:0]      mul_result,
  input  logic                    mul_done
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [IW-1:0] LAST_C    = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                 busy_q, busy_d;
  logic                 error_q, error_d;
  logic                 mul_start_q, mul_start_d;
  logic [WIDTH-1:0]     mul_multiplier_q, mul_multiplier_d;
  logic [WIDTH-1:0]     mul_multiplicand_q, mul_multiplicand_d;

  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic [IW-1:0]        cand_idx;
  logic [IW-1:0]        rr_next;
  logic                 timeout;

  // First requesting index at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand_idx = IW'((32'(rr_ptr_q) + i) % NREQ);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    owner_d            = owner_q;
    rr_ptr_d           = rr_ptr_q;
    cnt_d              = cnt_q;
    grant_d            = '0;
    rsp_valid_d        = '0;
    rsp_data_d         = rsp_data_q;
    error_d            = error_q;
    mul_start_d        = mul_start_q;
    mul_multiplier_d   = mul_multiplier_q;
    mul_multiplicand_d = mul_multiplicand_q;
    rr_next            = (owner_q == LAST_C) ? '0 : owner_q + IW'(1);
    // Saturating compare so a timeout reached on the START->WAIT edge still fires in WAIT.
    timeout            = (cnt_q >= TIMEOUT_C - CW'(1));

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d            = START;
          owner_d            = pick_idx;
          grant_d[pick_idx]  = 1'b1;
          mul_start_d        = 1'b1;
          cnt_d              = '0;
          mul_multiplier_d   = req_multiplier[pick_idx*WIDTH +: WIDTH];
          mul_multiplicand_d = req_multiplicand[pick_idx*WIDTH +: WIDTH];
        end
      end
      START: begin
        cnt_d = timeout ? TIMEOUT_C : cnt_q + CW'(1);
        if (!mul_done) begin
          mul_start_d = 1'b0;
          state_d     = WAIT;
        end else if (timeout) begin
          mul_start_d          = 1'b0;
          error_d              = 1'b1;
          rsp_data_d           = '0;
          rsp_valid_d[owner_q] = 1'b1;
          rr_ptr_d             = rr_next;
          state_d              = RESP;
        end
      end
      WAIT: begin
        cnt_d = timeout ? TIMEOUT_C : cnt_q + CW'(1);
        if (mul_done) begin
          rsp_data_d           = mul_result;
          rsp_valid_d[owner_q] = 1'b1;
          rr_ptr_d             = rr_next;
          state_d              = RESP;
        end else if (timeout) begin
          mul_start_d          = 1'b0;
          error_d              = 1'b1;
          rsp_data_d           = '0;
          rsp_valid_d[owner_q] = 1'b1;
          rr_ptr_d             = rr_next;
          state_d              = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q            <= IDLE;
      owner_q            <= '0;
      rr_ptr_q           <= '0;
      cnt_q              <= '0;
      grant_q            <= '0;
      rsp_valid_q        <= '0;
      rsp_data_q         <= '0;
      busy_q             <= 1'b0;
      error_q            <= 1'b0;
      mul_start_q        <= 1'b0;
      mul_multiplier_q   <= '0;
      mul_multiplicand_q <= '0;
    end else begin
      state_q            <= state_d;
      owner_q            <= owner_d;
      rr_ptr_q           <= rr_ptr_d;
      cnt_q              <= cnt_d;
      grant_q            <= grant_d;
      rsp_valid_q        <= rsp_valid_d;
      rsp_data_q         <= rsp_data_d;
      busy_q             <= busy_d;
      error_q            <= error_d;
      mul_start_q        <= mul_start_d;
      mul_multiplier_q   <= mul_multiplier_d;
      mul_multiplicand_q <= mul_multiplicand_d;
    end
  end

  assign grant            = grant_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign busy             = busy_q;
  assign error            = error_q;
  assign mul_start        = mul_start_q;
  assign mul_multiplier   = mul_multiplier_q;
  assign mul_multiplicand = mul_multiplicand_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: one instance with a reference multiplier,
// one with a multiplier stuck idle to exercise the watchdog.
module tb_mul_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned NREQ  = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_mr = '0, req_md = '0;
  logic [NREQ-1:0]       grant, rsp_valid;
  logic [2*WIDTH-1:0]    rsp_data;
  logic                  busy, error, mul_start;
  logic [WIDTH-1:0]      mul_mr, mul_md;
  logic [2*WIDTH-1:0]    mul_result;
  logic                  mul_done;

  logic [NREQ-1:0]       w_req = '0;
  logic [NREQ*WIDTH-1:0] w_req_mr = '0, w_req_md = '0;
  logic [NREQ-1:0]       w_grant, w_rsp_valid;
  logic [2*WIDTH-1:0]    w_rsp_data;
  logic                  w_busy, w_error, w_mul_start;
  logic [WIDTH-1:0]      w_mul_mr, w_mul_md;
  logic [2*WIDTH-1:0]    w_mul_result;
  logic                  w_mul_done;
  assign w_mul_done   = 1'b1;
  assign w_mul_result = 64'hDEAD_BEEF_1234_5678;

  mul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(255)) dut (
    .clock(clock), .reset(reset), .req(req),
    .req_multiplier(req_mr), .req_multiplicand(req_md),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .error(error), .mul_start(mul_start),
    .mul_multiplier(mul_mr), .mul_multiplicand(mul_md),
    .mul_result(mul_result), .mul_done(mul_done)
  );

  mul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(20)) dut_wd (
    .clock(clock), .reset(reset), .req(w_req),
    .req_multiplier(w_req_mr), .req_multiplicand(w_req_md),
    .grant(w_grant), .rsp_valid(w_rsp_valid), .rsp_data(w_rsp_data),
    .busy(w_busy), .error(w_error), .mul_start(w_mul_start),
    .mul_multiplier(w_mul_mr), .mul_multiplicand(w_mul_md),
    .mul_result(w_mul_result), .mul_done(w_mul_done)
  );

  // Reference multiplier: done falls one cycle after start is sampled and
  // returns high WIDTH/2+2 cycles later with the product.
  logic        m_armed;
  int          m_cnt;
  logic [63:0] m_prod;
  always @(posedge clock) begin
    if (!reset) begin
      mul_done   <= 1'b1;
      m_armed    <= 1'b0;
      m_cnt      <= 0;
      mul_result <= '0;
      m_prod     <= '0;
    end else if (mul_done && !m_armed && mul_start) begin
      m_armed <= 1'b1;
      m_prod  <= {32'b0, mul_mr} * {32'b0, mul_md};
    end else if (m_armed) begin
      m_armed  <= 1'b0;
      mul_done <= 1'b0;
      m_cnt    <= WIDTH/2 + 2;
    end else if (!mul_done) begin
      if (m_cnt == 1) begin
        mul_done   <= 1'b1;
        mul_result <= m_prod;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  typedef struct { int idx; logic [63:0] prod; } exp_t;
  exp_t exp_q[$];
  int   grant_q[$];
  int   checks = 0;
  int   passed = 0;

  exp_t            mon_e;
  int              mon_g;
  logic [NREQ-1:0] mon_bits;

  always @(negedge clock) begin
    if (reset) begin
      if (grant !== '0) begin
        checks++;
        if (grant_q.size() == 0) $display("FAIL unexpected_grant got=%b want=none", grant);
        else begin
          mon_g    = grant_q.pop_front();
          mon_bits = 4'b0001 << mon_g;
          if (grant !== mon_bits) $display("FAIL grant_order got=%b want=%b", grant, mon_bits);
          else passed++;
        end
      end
      if (rsp_valid !== '0) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL unexpected_rsp got=%b want=none", rsp_valid);
        else begin
          mon_e    = exp_q.pop_front();
          mon_bits = 4'b0001 << mon_e.idx;
          if (rsp_valid !== mon_bits || rsp_data !== mon_e.prod)
            $display("FAIL rsp got=%b/%h want=%b/%h", rsp_valid, rsp_data, mon_bits, mon_e.prod);
          else passed++;
        end
      end
      if (grant !== '0 || rsp_valid !== '0) begin
        checks++;
        if (grant !== '0 && rsp_valid !== '0)
          $display("FAIL grant_rsp_overlap got=%b/%b want=exclusive", grant, rsp_valid);
        else passed++;
      end
    end
  end

  task automatic wait_rsp(input int n, input logic [NREQ-1:0] drop, input int bound);
    int seen = 0;
    for (int c = 0; c < bound && seen < n; c++) begin
      @(negedge clock);
      if (rsp_valid !== '0) begin
        seen++;
        req = req & ~(rsp_valid & drop);
      end
    end
    checks++;
    if (seen < n) $display("FAIL rsp_timeout got=%0d want=%0d", seen, n);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({grant, rsp_valid, busy, error, mul_start} !== '0)
      $display("FAIL reset_ctrl got=%b want=0", {grant, rsp_valid, busy, error, mul_start});
    else passed++;
    checks++;
    if ({rsp_data, mul_mr, mul_md} !== '0)
      $display("FAIL reset_data got=%h want=0", {rsp_data, mul_mr, mul_md});
    else passed++;
    checks++;
    if ({w_busy, w_error, w_grant} !== '0)
      $display("FAIL reset_wd got=%b want=0", {w_busy, w_error, w_grant});
    else passed++;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_fairness();
    req_mr[0*WIDTH +: WIDTH] = 1;     req_md[0*WIDTH +: WIDTH] = 11;
    req_mr[1*WIDTH +: WIDTH] = 113;   req_md[1*WIDTH +: WIDTH] = 31415;
    req_mr[2*WIDTH +: WIDTH] = 31415; req_md[2*WIDTH +: WIDTH] = 113;
    req_mr[3*WIDTH +: WIDTH] = 35;    req_md[3*WIDTH +: WIDTH] = 63;
    grant_q = '{0, 1, 2, 3, 0};
    exp_q.push_back('{0, 64'd11});
    exp_q.push_back('{1, 64'd3549895});
    exp_q.push_back('{2, 64'd3549895});
    exp_q.push_back('{3, 64'd2205});
    exp_q.push_back('{0, 64'd11});
    req = 4'b1111;
    wait_rsp(4, 4'b1110, 200);
    wait_rsp(1, 4'b1111, 60);
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || grant_q.size() != 0)
      $display("FAIL fairness_drain got=%0d/%0d want=0/0", exp_q.size(), grant_q.size());
    else passed++;
  endtask

  task automatic test_single();
    req_mr[0 +: WIDTH] = 35;
    req_md[0 +: WIDTH] = 17;
    grant_q.push_back(0);
    exp_q.push_back('{0, 64'd595});
    req = 4'b0001;
    @(negedge clock);
    checks++;
    if ({grant, busy, mul_start} !== 6'b0001_11)
      $display("FAIL single_issue got=%b want=000111", {grant, busy, mul_start});
    else passed++;
    checks++;
    if (mul_mr !== 32'd35 || mul_md !== 32'd17)
      $display("FAIL single_operands got=%0d,%0d want=35,17", mul_mr, mul_md);
    else passed++;
    wait_rsp(1, 4'b1111, 60);
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0) $display("FAIL single_busy_low got=%b want=0", busy);
    else passed++;
  endtask

  task automatic test_extremes();
    int          idx_t [3] = '{1, 2, 3};
    logic [31:0] a_t   [3] = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
    logic [31:0] b_t   [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3};
    logic [63:0] p_t   [3] = '{64'hFFFF_FFFE_0000_0001, 64'h0, 64'h2_FFFF_FFFD};
    for (int k = 0; k < 3; k++) begin
      req_mr[idx_t[k]*WIDTH +: WIDTH] = a_t[k];
      req_md[idx_t[k]*WIDTH +: WIDTH] = b_t[k];
      grant_q.push_back(idx_t[k]);
      exp_q.push_back('{idx_t[k], p_t[k]});
      req = 4'b0001 << idx_t[k];
      wait_rsp(1, 4'b1111, 60);
      repeat (2) @(negedge clock);
      checks++;
      if (rsp_data !== p_t[k]) $display("FAIL extreme_hold got=%h want=%h", rsp_data, p_t[k]);
      else passed++;
    end
  endtask

  task automatic test_wraparound();
    req_mr[2*WIDTH +: WIDTH] = 5; req_md[2*WIDTH +: WIDTH] = 6;
    grant_q.push_back(2);
    exp_q.push_back('{2, 64'd30});
    req = 4'b0100;
    wait_rsp(1, 4'b1111, 60);
    @(negedge clock);
    req_mr[0 +: WIDTH] = 7;       req_md[0 +: WIDTH] = 8;
    req_mr[2*WIDTH +: WIDTH] = 9; req_md[2*WIDTH +: WIDTH] = 10;
    grant_q.push_back(0); grant_q.push_back(2);
    exp_q.push_back('{0, 64'd56});
    exp_q.push_back('{2, 64'd90});
    req = 4'b0101;
    wait_rsp(2, 4'b1111, 120);
    repeat (2) @(negedge clock);
    checks++;
    if (grant_q.size() != 0) $display("FAIL wrap_drain got=%0d want=0", grant_q.size());
    else passed++;
  endtask

  task automatic test_watchdog();
    int cyc;
    for (int r = 0; r < 2; r++) begin
      logic [NREQ-1:0] who;
      who = (r == 0) ? 4'b0010 : 4'b0001;
      w_req_mr = {4{32'd5}};
      w_req_md = {4{32'd6}};
      w_req = who;
      cyc = 0;
      while (w_grant === '0 && cyc < 5) begin @(negedge clock); cyc++; end
      checks++;
      if (w_grant !== who || w_mul_start !== 1'b1)
        $display("FAIL wd_grant got=%b/%b want=%b/1", w_grant, w_mul_start, who);
      else passed++;
      cyc = 0;
      while (w_rsp_valid === '0 && cyc < 40) begin @(negedge clock); cyc++; end
      checks++;
      if (w_rsp_valid !== who || w_rsp_data !== '0 || w_error !== 1'b1)
        $display("FAIL wd_rsp got=%b/%h/%b want=%b/0/1", w_rsp_valid, w_rsp_data, w_error, who);
      else passed++;
      checks++;
      if (cyc < 15 || cyc > 25) $display("FAIL wd_latency got=%0d want=15..25", cyc);
      else passed++;
      w_req = '0;
      repeat (3) @(negedge clock);
      checks++;
      if (w_error !== 1'b1 || w_busy !== 1'b0 || w_mul_start !== 1'b0)
        $display("FAIL wd_sticky got=%b%b%b want=100", w_error, w_busy, w_mul_start);
      else passed++;
    end
  endtask

  task automatic test_reset_midop();
    int cyc;
    req_mr[1*WIDTH +: WIDTH] = 100; req_md[1*WIDTH +: WIDTH] = 200;
    grant_q.push_back(1);
    req = 4'b0010;
    cyc = 0;
    while (grant_q.size() != 0 && cyc < 5) begin @(negedge clock); cyc++; end
    repeat (6) @(negedge clock);
    checks++;
    if (busy !== 1'b1 || mul_start !== 1'b0 || mul_done !== 1'b0)
      $display("FAIL midop_wait got=%b%b%b want=100", busy, mul_start, mul_done);
    else passed++;
    reset = 1'b0;
    req   = '0;
    @(negedge clock);
    checks++;
    if ({grant, rsp_valid, busy, error, mul_start, w_error} !== '0)
      $display("FAIL midop_reset_ctrl got=%b want=0", {grant, rsp_valid, busy, error, mul_start, w_error});
    else passed++;
    checks++;
    if ({rsp_data, mul_mr, mul_md} !== '0)
      $display("FAIL midop_reset_data got=%h want=0", {rsp_data, mul_mr, mul_md});
    else passed++;
    reset = 1'b1;
    repeat (30) @(negedge clock);
    req_mr[2*WIDTH +: WIDTH] = 12; req_md[2*WIDTH +: WIDTH] = 12;
    grant_q.push_back(2);
    exp_q.push_back('{2, 64'd144});
    req = 4'b0100;
    wait_rsp(1, 4'b1111, 60);
    repeat (2) @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0)
      $display("FAIL midop_recover got=%0d/%b want=0/0", exp_q.size(), busy);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    @(negedge clock);
    test_reset();
    test_fairness();
    test_single();
    test_extremes();
    test_wraparound();
    test_watchdog();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin controller that shares one bit-pair unsigned multiplier among NREQ requesters. It arbitrates pending requests and latches the winner's operands. It then sequences the multiplier's start/done handshake and returns the 2*WIDTH-bit product to the winning requester with a one-cycle response strobe. It sits between the requesting execution units and the single multiplier instance, and includes a watchdog for a hung multiplier.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 255, max cycles from start accepted to done before error
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clock edge)
- req  in  NREQ  per-requester request level; held until own rsp_valid
- req_multiplier  in  NREQ*WIDTH  packed operands, slice i = requester i; stable while req[i]
- req_multiplicand  in  NREQ*WIDTH  packed operands, slice i = requester i
- grant  out  NREQ  one-hot, one-cycle pulse when requester i's operands are latched
- rsp_valid  out  NREQ  one-hot, one-cycle pulse when rsp_data belongs to requester i
- rsp_data  out  2*WIDTH  product of last completed operation, held until next completion
- busy  out  1  high in every state except IDLE
- error  out  1  sticky watchdog flag; cleared only by reset
- mul_start  out  1  to multiplier start
- mul_multiplier, mul_multiplicand  out  WIDTH each  latched operands to multiplier
- mul_result  in  2*WIDTH  multiplier product
- mul_done  in  1  multiplier done: high when idle, low while computing

## Operation
- States: IDLE, START, WAIT, RESP.
- IDLE: if any req bit is set, pick the first set bit at or after rr_ptr, wrapping modulo NREQ. Latch its operands into mul_* registers, store owner index, pulse grant[owner], set mul_start=1, go to START. If req is 0, stay.
- START: hold mul_start=1 until mul_done==0 is sampled, then set mul_start=0 and go to WAIT. Start must drop before the multiplier returns to idle so the operation is not reissued.
- WAIT: when mul_done==1, capture mul_result into rsp_data, pulse rsp_valid[owner], set rr_ptr=(owner+1) mod NREQ, go to RESP.
- RESP: one cycle back to IDLE. req[owner] is not re-arbitrated in this cycle, which gives the requester time to drop req.
- Watchdog: counter clears at grant and increments in START/WAIT. When it reaches TIMEOUT:
  - set error=1 and mul_start=0;
  - set rsp_data=0 and pulse rsp_valid[owner];
  - advance rr_ptr and go to RESP.
- A requester that drops req mid-operation still receives its rsp_valid pulse. Operands are never re-read after grant.
- Reset (reset==0 at an edge), including mid-operation:
  - state=IDLE, rr_ptr=0, counter=0;
  - grant=0, rsp_valid=0, rsp_data=0, busy=0, error=0;
  - mul_start=0, mul_multiplier=0, mul_multiplicand=0.
  - Any operation in flight is abandoned with no rsp_valid.

## Timing
- All outputs are registered. Arbitration is evaluated only in IDLE.
- Edge E0 samples req in IDLE. From E0: grant, mul_start and busy are all 1, and the operands are valid.
- With the reference multiplier, mul_done falls 1 cycle after start is sampled. It returns high 1+WIDTH/2+1 cycles after that. rsp_valid follows 1 cycle after done is seen high.
- Back-to-back issue: the next grant comes no earlier than 2 cycles after rsp_valid (RESP, then IDLE).
- Simultaneous requests are served strictly in round-robin order. A requester waits at most NREQ-1 operations.
- grant and rsp_valid are never both asserted in the same cycle.

## Test plan
- Single request: req[0]=1, 35×17. Expect grant[0] 1 cycle later, rsp_valid[0] with rsp_data=595, busy low 2 cycles after.
- Fairness: req=4'b1111 held continuously with distinct operands (1×11, 113×31415, 31415×113, 35×63). Expect grants in order 0,1,2,3,0. Products must be 11, 3549895, 3549895, 2205.
- Extremes: 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE00000001; 0×0xFFFFFFFF → 0; 0xFFFFFFFF×3 → 0x2FFFFFFFD.
- Wrap-around: rr_ptr=3 after serving requester 2, req=4'b0101. Expect requester 0 served next, then 2.
- Watchdog: model holds mul_done=1 forever, TIMEOUT=20. Expect rsp_valid[owner] with rsp_data=0 and error=1 sticky. Next request is still arbitrated normally.
- Reset mid-operation: reset=0 for one edge while in WAIT. Next cycle all outputs are 0, busy=0, and no rsp_valid for the abandoned request. A new request then completes correctly.
